// File: rtl/svd_div_pkg.sv
// Shared types and constants for the SVD datapath signed divider.
package svd_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit patterns of the most positive / most negative w-bit values; callers truncate to w bits.
    function automatic logic [63:0] max_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step on the {P, Q} pair.
module div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   p_new,
    output logic [WIDTH-1:0] q_new
);

    logic [WIDTH:0] p_sh;

    always_comb begin
        p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
        if (!p[WIDTH]) begin
            p_new = p_sh - {1'b0, dvs};
        end else begin
            p_new = p_sh + {1'b0, dvs};
        end
        q_new = {q[WIDTH-2:0], ~p_new[WIDTH]};
    end

endmodule

// File: rtl/nonrestoring_div.sv
// Iterative signed divider: magnitudes are divided one step per clock, then signs and
// the divide-by-zero / overflow overrides are applied in a single fix-up cycle.
module nonrestoring_div
    import svd_div_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MINNEG = WIDTH'(min_neg(WIDTH));

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             neg_dd_q, neg_dd_d;
    logic             neg_dv_q, neg_dv_d;
    logic             dz_pend_q, dz_pend_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quot_sgn;
    logic [WIDTH-1:0] rem_sgn;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p     (p_q),
        .q     (q_q),
        .dvs   (dvs_q),
        .p_new (p_step),
        .q_new (q_step)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        dividend_d  = dividend_q;
        neg_dd_d    = neg_dd_q;
        neg_dv_d    = neg_dv_q;
        dz_pend_d   = dz_pend_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;

        // A negative final partial remainder is restored by one add of the divisor.
        rem_mag  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + dvs_q) : p_q[WIDTH-1:0];
        quot_sgn = (neg_dd_q ^ neg_dv_q) ? -q_q : q_q;
        rem_sgn  = neg_dd_q ? -rem_mag : rem_mag;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    p_d        = '0;
                    q_d        = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_d      = divisor[WIDTH-1] ? -divisor : divisor;
                    dividend_d = dividend;
                    neg_dd_d   = dividend[WIDTH-1];
                    neg_dv_d   = divisor[WIDTH-1];
                    dz_pend_d  = (divisor == '0);
                    ovf_pend_d = (dividend == MINNEG) && (divisor == '1);
                    cnt_d      = CW'(WIDTH - 1);
                    state_d    = ITER;
                end
            end
            ITER: begin
                p_d   = p_step;
                q_d   = q_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                div_zero_d = dz_pend_q;
                ovf_d      = ovf_pend_q;
                if (dz_pend_q) begin
                    quotient_d  = neg_dd_q ? MINNEG : MAXPOS;
                    remainder_d = dividend_q;
                end else if (ovf_pend_q) begin
                    quotient_d  = MAXPOS;
                    remainder_d = '0;
                end else begin
                    quotient_d  = quot_sgn;
                    remainder_d = rem_sgn;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: working registers are not reset; each is loaded on accept before it is ever read.
    always_ff @(posedge clk) begin
        cnt_q      <= cnt_d;
        p_q        <= p_d;
        q_q        <= q_d;
        dvs_q      <= dvs_d;
        dividend_q <= dividend_d;
        neg_dd_q   <= neg_dd_d;
        neg_dv_q   <= neg_dv_d;
        dz_pend_q  <= dz_pend_d;
        ovf_pend_q <= ovf_pend_d;
    end

endmodule

// File: tb/tb_nonrestoring_div.sv
// Scoreboard bench for nonrestoring_div: reference results come from integer / and %.
module tb_nonrestoring_div;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         ovf;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    nonrestoring_div #(.WIDTH(W), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai    = a;
        bi    = b;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (bi == 0) begin
            e.dz = 1'b1;
            e.q  = (ai >= 0) ? 24'h7FFFFF : 24'h800000;
            e.r  = a;
        end else if (ai == -8388608 && bi == -1) begin
            e.ovf = 1'b1;
            e.q   = 24'h7FFFFF;
            e.r   = '0;
        end else begin
            e.q = W'(ai / bi);
            e.r = W'(ai % bi);
        end
        return e;
    endfunction

    // Drive one operand pair at a negedge; the accept happens on the following posedge.
    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the result, checking latency, then pop and compare against the scoreboard.
    task automatic collect(input string tag);
        int   edges;
        exp_t e;
        edges = 0;
        check({tag, "_v_early"}, out_valid, 0);
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, W + 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_quot"}, quotient, e.q);
            check({tag, "_rem"}, remainder, e.r);
            check({tag, "_dz"}, div_zero, e.dz);
            check({tag, "_ovf"}, ovf, e.ovf);
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        send(tag, a, b);
        collect(tag);
        @(negedge clk);
        check({tag, "_v_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] hold_q;
        logic [W-1:0] hold_r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_flags", {div_zero, ovf}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        op("p100_p7", 24'sd100, 24'sd7);
        op("n100_p7", -24'sd100, 24'sd7);
        op("p100_n7", 24'sd100, -24'sd7);
        op("n100_n7", -24'sd100, -24'sd7);
        op("minneg_n1", 24'h800000, 24'hFFFFFF);
        op("minneg_p1", 24'h800000, 24'd1);
        op("p5_zero", 24'sd5, 24'd0);
        op("n5_zero", -24'sd5, 24'd0);
        op("small_dd", -24'sd6, 24'sd9);
        op("max_max", 24'h7FFFFF, 24'h7FFFFF);
        op("minneg_minneg", 24'h800000, 24'h800000);

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            if (i % 2 == 0) begin
                rb = W'($urandom_range(1, 50));
                if (i == 2) rb = -rb;
            end else begin
                rb = W'($urandom);
            end
            op($sformatf("rand%0d", i), ra, rb);
        end

        // Back-pressure: result must hold while out_ready is low and new operands are ignored.
        out_ready = 1'b0;
        send("bp", 24'sd3, 24'sd10);
        collect("bp");
        hold_q = quotient;
        hold_r = remainder;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            check($sformatf("bp_hold_v%0d", i), out_valid, 1);
            check($sformatf("bp_in_ready%0d", i), in_ready, 0);
            check($sformatf("bp_hold_q%0d", i), quotient, hold_q);
            check($sformatf("bp_hold_r%0d", i), remainder, hold_r);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_v_drop", out_valid, 0);
        check("bp_ready_back", in_ready, 1);
        check("bp_keep_q", quotient, 0);
        check("bp_keep_r", remainder, 3);

        // Abort mid-iteration with reset; no result may appear afterwards.
        send("abort", 24'sd1000, 24'sd3);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_quot", quotient, 0);
        check("abort_rem", remainder, 0);
        check("abort_flags", {div_zero, ovf}, 0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_ready_back", in_ready, 1);
        check("abort_no_result", out_valid, 0);
        op("p1000_p3", 24'sd1000, 24'sd3);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
